// File: rtl/psum_reduce_hub.sv
// N-core partial-sum exchange hub: per-core input FIFOs, a sum/max reducer that
// fires once every channel has a word, and one shared output FIFO.
module psum_reduce_hub #(
   parameter int n_core = 4,
   parameter int bw_sum = 23,
   parameter int depth  = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [n_core-1:0]                    wr_sum,
   input  logic [n_core*bw_sum-1:0]             sum_in,
   output logic [n_core-1:0]                    in_full,
   input  logic                                 mode,
   input  logic                                 rd_total,
   output logic [bw_sum+$clog2(n_core)-1:0]     total_out,
   output logic                                 total_valid,
   output logic                                 out_full,
   output logic [n_core-1:0]                    ovf_err,
   input  logic                                 clr_err
);

   localparam int bw_tot = bw_sum + $clog2(n_core);
   localparam int aw     = $clog2(depth);
   localparam logic [aw:0] cnt_full = (aw+1)'(depth);

   typedef enum logic [1:0] {IDLE, REDUCE, WRITE} state_t;

   state_t                   state_reg, state_next;
   logic                     pop_all;
   logic                     do_write;
   logic [n_core-1:0]        chan_empty;
   logic [n_core*bw_sum-1:0] operand_flat;
   logic                     mode_reg;
   logic [bw_tot-1:0]        result_reg, result_next;
   logic [bw_tot-1:0]        red_sum;
   logic [bw_sum-1:0]        red_max;

   // Per-channel input FIFO plus the operand register it feeds.
   for (genvar gi = 0; gi < n_core; gi++) begin : g_in
      logic [bw_sum-1:0] mem [depth];
      logic [aw-1:0]     wr_ptr_reg, rd_ptr_reg;
      logic [aw:0]       count_reg;
      logic [bw_sum-1:0] operand_reg;
      logic              push;

      assign in_full[gi]    = (count_reg == cnt_full);
      assign chan_empty[gi] = (count_reg == '0);
      assign push           = wr_sum[gi] && !in_full[gi];
      assign operand_flat[gi*bw_sum +: bw_sum] = operand_reg;

      always_ff @(posedge clk) begin
         if (push)
            mem[wr_ptr_reg] <= sum_in[gi*bw_sum +: bw_sum];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            operand_reg <= '0;
         end else begin
            if (push)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_all) begin
               rd_ptr_reg  <= rd_ptr_reg + 1'b1;
               operand_reg <= mem[rd_ptr_reg];
            end
            case ({push, pop_all})
               2'b10:   count_reg <= count_reg + 1'b1;
               2'b01:   count_reg <= count_reg - 1'b1;
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   // Overflow flags: a new overflow in the clearing cycle still sticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf_err <= '0;
      else
         ovf_err <= (clr_err ? '0 : ovf_err) | (wr_sum & in_full);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      pop_all    = 1'b0;
      do_write   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!(|chan_empty) && !out_full) begin
               pop_all    = 1'b1;
               state_next = REDUCE;
            end
         end
         REDUCE: state_next = WRITE;
         WRITE: begin
            do_write   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      red_sum = '0;
      red_max = '0;
      for (int i = 0; i < n_core; i++) begin
         red_sum = red_sum + bw_tot'(operand_flat[i*bw_sum +: bw_sum]);
         if (operand_flat[i*bw_sum +: bw_sum] > red_max)
            red_max = operand_flat[i*bw_sum +: bw_sum];
      end
      result_next = mode_reg ? bw_tot'(red_max) : red_sum;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_reg   <= 1'b0;
         result_reg <= '0;
      end else begin
         if (pop_all)
            mode_reg <= mode;
         if (state_reg == REDUCE)
            result_reg <= result_next;
      end
   end

   // Shared output FIFO; space in WRITE is guaranteed by the IDLE out_full check.
   logic [bw_tot-1:0] out_mem [depth];
   logic [aw-1:0]     out_wr_ptr_reg, out_rd_ptr_reg;
   logic [aw:0]       out_count_reg;
   logic              out_pop;

   assign total_valid = (out_count_reg != '0);
   assign out_full    = (out_count_reg == cnt_full);
   assign out_pop     = rd_total && total_valid;
   assign total_out   = total_valid ? out_mem[out_rd_ptr_reg] : '0;

   always_ff @(posedge clk) begin
      if (do_write)
         out_mem[out_wr_ptr_reg] <= result_reg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_wr_ptr_reg <= '0;
         out_rd_ptr_reg <= '0;
         out_count_reg  <= '0;
      end else begin
         if (do_write)
            out_wr_ptr_reg <= out_wr_ptr_reg + 1'b1;
         if (out_pop)
            out_rd_ptr_reg <= out_rd_ptr_reg + 1'b1;
         case ({do_write, out_pop})
            2'b10:   out_count_reg <= out_count_reg + 1'b1;
            2'b01:   out_count_reg <= out_count_reg - 1'b1;
            default: out_count_reg <= out_count_reg;
         endcase
      end
   end

endmodule
